// File: rtl/sprite_motion_ctrl.sv
// Sprite position generator: steps sprite_x/sprite_y once every FRAME_DIV vsync falls.
// Bounces at the visible limits; define SPRITE_MOTION_WRAP_EN to wrap around instead.
module sprite_motion_ctrl #(
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int SPRITE_W  = 32,
    parameter int SPRITE_H  = 32,
    parameter int START_X   = 304,
    parameter int START_Y   = 224,
    parameter int SPEED_X   = 4,
    parameter int SPEED_Y   = 2,
    parameter int FRAME_DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       start,
    input  logic       pause,
    output logic [9:0] sprite_x,
    output logic [9:0] sprite_y,
    output logic       moving,
    output logic       bounce_x,
    output logic       bounce_y
);

    localparam int X_MAX = SCREEN_W - SPRITE_W;
    localparam int Y_MAX = SCREEN_H - SPRITE_H;
    localparam logic [9:0] X_LIM  = 10'(X_MAX);
    localparam logic [9:0] Y_LIM  = 10'(Y_MAX);
    localparam logic [9:0] X_INIT = 10'(START_X);
    localparam logic [9:0] Y_INIT = 10'(START_Y);
    localparam logic [9:0] X_STEP = 10'(SPEED_X);
    localparam logic [9:0] Y_STEP = 10'(SPEED_Y);
    localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [9:0] pos;
        logic       dir_neg;
        logic       bounce;
    } axis_t;

    // One axis step; the 11-bit sum keeps pos+speed from wrapping before the limit test.
    function automatic axis_t step_axis(input logic [9:0] pos, input logic dir_neg,
                                        input logic [9:0] speed, input logic [9:0] lim);
        logic [10:0] nxt;
        axis_t       r;
        r.pos     = pos;
        r.dir_neg = dir_neg;
        r.bounce  = 1'b0;
        nxt       = {1'b0, pos} + {1'b0, speed};
`ifdef SPRITE_MOTION_WRAP_EN
        if (!dir_neg) begin
            r.pos = (nxt > {1'b0, lim}) ? 10'd0 : nxt[9:0];
        end else begin
            r.pos = (pos < speed) ? lim : pos - speed;
        end
`else
        if (!dir_neg) begin
            if (nxt >= {1'b0, lim}) begin
                r.pos     = lim;
                r.dir_neg = 1'b1;
                r.bounce  = 1'b1;
            end else begin
                r.pos = nxt[9:0];
            end
        end else begin
            if (pos <= speed) begin
                r.pos     = 10'd0;
                r.dir_neg = 1'b0;
                r.bounce  = 1'b1;
            end else begin
                r.pos = pos - speed;
            end
        end
`endif
        return r;
    endfunction

    state_t           state_q;
    state_t           state_nxt;
    logic             vsync_q;
    logic             fall;
    logic             reload;
    logic             tick;
    logic             update;
    logic [CNT_W-1:0] frame_cnt;
    logic             dir_x_neg;
    logic             dir_y_neg;
    axis_t            ax_nxt;
    axis_t            ay_nxt;

    assign fall   = vsync_q & ~vsync;
    assign update = tick & (frame_cnt == CNT_LAST);
    assign moving = (state_q == RUN);
    assign ax_nxt = step_axis(sprite_x, dir_x_neg, X_STEP, X_LIM);
    assign ay_nxt = step_axis(sprite_y, dir_y_neg, Y_STEP, Y_LIM);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // start outranks pause in every state; pause only matters once running.
    always_comb begin
        state_nxt = state_q;
        reload    = 1'b0;
        tick      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    reload    = 1'b1;
                end
            end
            RUN: begin
                if (start) begin
                    reload = 1'b1;
                end else if (pause) begin
                    state_nxt = HOLD;
                end else begin
                    tick = fall;
                end
            end
            HOLD: begin
                if (start) begin
                    state_nxt = RUN;
                    reload    = 1'b1;
                end else if (!pause) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Positions move on the edge that first samples vsync low, so they settle before the next frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vsync_q   <= 1'b1;
            frame_cnt <= '0;
            sprite_x  <= X_INIT;
            sprite_y  <= Y_INIT;
            dir_x_neg <= 1'b0;
            dir_y_neg <= 1'b0;
            bounce_x  <= 1'b0;
            bounce_y  <= 1'b0;
        end else begin
            vsync_q  <= vsync;
            bounce_x <= 1'b0;
            bounce_y <= 1'b0;
            if (reload) begin
                frame_cnt <= '0;
                sprite_x  <= X_INIT;
                sprite_y  <= Y_INIT;
                dir_x_neg <= 1'b0;
                dir_y_neg <= 1'b0;
            end else if (update) begin
                frame_cnt <= '0;
                sprite_x  <= ax_nxt.pos;
                sprite_y  <= ay_nxt.pos;
                dir_x_neg <= ax_nxt.dir_neg;
                dir_y_neg <= ay_nxt.dir_neg;
                bounce_x  <= ax_nxt.bounce;
                bounce_y  <= ay_nxt.bounce;
            end else if (tick) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule
